// File: rtl/alu_exec_unit.sv
// Execute-stage ALU for the single-cycle MIPS datapath: ALU control decode, 32-bit ALU,
// registered result/zero/overflow/branch_taken. Define ALU_EXT_OPS_EN to add xor/sltu.
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        branch,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow,
  output logic        branch_taken
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_INV  = 4'b1111;

  logic [31:0] res_d, res_q;
  logic [31:0] sum, diff;
  logic        ovf_d, ovf_q;
  logic        zero_d, zero_q;
  logic        bt_d, bt_q;

  always_comb begin
    alu_ctrl = OP_INV;
    case (alu_op)
      2'b00, 2'b11: alu_ctrl = OP_ADD;
      2'b01:        alu_ctrl = OP_SUB;
      default: begin
        case (funct)
          6'b100000: alu_ctrl = OP_ADD;
          6'b100010: alu_ctrl = OP_SUB;
          6'b100100: alu_ctrl = OP_AND;
          6'b100101: alu_ctrl = OP_OR;
          6'b101010: alu_ctrl = OP_SLT;
          6'b100111: alu_ctrl = OP_NOR;
`ifdef ALU_EXT_OPS_EN
          6'b100110: alu_ctrl = OP_XOR;
          6'b101011: alu_ctrl = OP_SLTU;
`endif
          default:   alu_ctrl = OP_INV;
        endcase
      end
    endcase
  end

  assign sum  = a + b;
  assign diff = a - b;

  // Unlisted ctrl codes (including the extended ones when disabled) fall to result 0.
  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    case (alu_ctrl)
      OP_AND: res_d = a & b;
      OP_OR:  res_d = a | b;
      OP_ADD: begin
        res_d = sum;
        ovf_d = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      OP_SUB: begin
        res_d = diff;
        ovf_d = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      OP_SLT: res_d = {31'b0, ($signed(a) < $signed(b))};
      OP_NOR: res_d = ~(a | b);
`ifdef ALU_EXT_OPS_EN
      OP_XOR:  res_d = a ^ b;
      OP_SLTU: res_d = {31'b0, (a < b)};
`endif
      default: res_d = '0;
    endcase
  end

  assign zero_d = (res_d == '0);
  assign bt_d   = branch & zero_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q  <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      bt_q   <= 1'b0;
    end else begin
      res_q  <= res_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
      bt_q   <= bt_d;
    end
  end

  assign result       = res_q;
  assign zero         = zero_q;
  assign overflow     = ovf_q;
  assign branch_taken = bt_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized traffic
// against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  alu_op = '0;
  logic [5:0]  funct = '0;
  logic [31:0] a = '0, b = '0;
  logic        branch = 1'b0;
  logic [3:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero, overflow, branch_taken;

  int checks = 0;
  int failures = 0;

  alu_exec_unit dut (
    .clk(clk), .rst(rst), .alu_op(alu_op), .funct(funct), .a(a), .b(b),
    .branch(branch), .alu_ctrl(alu_ctrl), .result(result), .zero(zero),
    .overflow(overflow), .branch_taken(branch_taken)
  );

  always #5 clk = ~clk;

`ifdef ALU_EXT_OPS_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  // Reference: decode by table, then evaluate with plain integer arithmetic.
  function automatic void model(input logic [1:0] op, input logic [5:0] fn,
                                input logic [31:0] x, input logic [31:0] y,
                                output logic [3:0] c, output logic [31:0] r,
                                output logic ov);
    longint sx, sy, s;
    sx = $signed(x);
    sy = $signed(y);
    c = 4'hF;
    if (op == 2'b00 || op == 2'b11) c = 4'h2;
    else if (op == 2'b01) c = 4'h6;
    else if (fn == 6'h20) c = 4'h2;
    else if (fn == 6'h22) c = 4'h6;
    else if (fn == 6'h24) c = 4'h0;
    else if (fn == 6'h25) c = 4'h1;
    else if (fn == 6'h2A) c = 4'h7;
    else if (fn == 6'h27) c = 4'hC;
    else if (EXT && fn == 6'h26) c = 4'h3;
    else if (EXT && fn == 6'h2B) c = 4'h8;
    r = 32'd0;
    ov = 1'b0;
    if (c == 4'h2) begin
      s = sx + sy; r = 32'(s);
      ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else if (c == 4'h6) begin
      s = sx - sy; r = 32'(s);
      ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else if (c == 4'h0) r = x & y;
    else if (c == 4'h1) r = x | y;
    else if (c == 4'h7) r = (sx < sy) ? 32'd1 : 32'd0;
    else if (c == 4'hC) r = ~(x | y);
    else if (c == 4'h3) r = x ^ y;
    else if (c == 4'h8) r = (x < y) ? 32'd1 : 32'd0;
  endfunction

  task automatic drive(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] x, input logic [31:0] y, input logic br);
    alu_op = op; funct = fn; a = x; b = y; branch = br;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 6'h27, $urandom, $urandom, 1'b1);
      step();
      checks++;
      if ({result, zero, overflow, branch_taken} !== 35'd0) begin
        failures++;
        $display("FAIL reset_hold: got r=%h z=%b o=%b bt=%b want all 0",
                 result, zero, overflow, branch_taken);
      end
    end
    drive(2'b00, 6'h00, 32'd5, 32'd6, 1'b0);
    #3 rst = 1'b1;
    step();
    checks++;
    if (result !== 32'd11 || zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got r=%h z=%b want r=0000000b z=0", result, zero);
    end
  endtask

  task automatic test_rtype_sweep();
    logic [5:0]  fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    logic [3:0]  ctl [6] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'hC, 4'h7};
    logic [31:0] res [6] = '{32'hFF, 32'hE1, 32'h0, 32'hFF, 32'hFFFF_FF00, 32'h0};
    for (int i = 0; i < 6; i++) begin
      drive(2'b10, fns[i], 32'h0000_00F0, 32'h0000_000F, 1'b0);
      #1;
      checks++;
      if (alu_ctrl !== ctl[i]) begin
        failures++;
        $display("FAIL sweep_ctrl funct=%h: got %b want %b", fns[i], alu_ctrl, ctl[i]);
      end
      step();
      checks++;
      if (result !== res[i] || zero !== (res[i] == 0)) begin
        failures++;
        $display("FAIL sweep_result funct=%h: got r=%h z=%b want r=%h", fns[i], result, zero, res[i]);
      end
    end
  endtask

  task automatic test_branch();
    drive(2'b01, 6'h00, 32'd7, 32'd7, 1'b1);
    step();
    checks++;
    if (zero !== 1'b1 || branch_taken !== 1'b1 || result !== 32'd0) begin
      failures++;
      $display("FAIL branch_eq: got r=%h z=%b bt=%b want r=0 z=1 bt=1", result, zero, branch_taken);
    end
    drive(2'b01, 6'h00, 32'd7, 32'd8, 1'b1);
    #2 branch = 1'b0;
    #2 branch = 1'b1;
    step();
    checks++;
    if (zero !== 1'b0 || branch_taken !== 1'b0 || result !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL branch_ne: got r=%h z=%b bt=%b want r=ffffffff z=0 bt=0", result, zero, branch_taken);
    end
  endtask

  task automatic test_overflow();
    drive(2'b00, 6'h00, 32'h7FFF_FFFF, 32'd1, 1'b0);
    step();
    checks++;
    if (result !== 32'h8000_0000 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_add: got r=%h o=%b want r=80000000 o=1", result, overflow);
    end
    drive(2'b10, 6'h22, 32'h8000_0000, 32'd1, 1'b0);
    step();
    checks++;
    if (result !== 32'h7FFF_FFFF || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sub: got r=%h o=%b want r=7fffffff o=1", result, overflow);
    end
    drive(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1, 1'b0);
    step();
    checks++;
    if (result !== 32'd1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_slt: got r=%h o=%b want r=1 o=0", result, overflow);
    end
  endtask

  task automatic test_config();
    logic [3:0]  ec  = EXT ? 4'h3 : 4'hF;
    logic [31:0] er  = EXT ? 32'h0FF0_0000 : 32'h0;
    logic        ez  = !EXT;
    drive(2'b10, 6'h26, 32'hF0F0_0000, 32'hFF00_0000, 1'b1);
    #1;
    checks++;
    if (alu_ctrl !== ec) begin
      failures++;
      $display("FAIL cfg_ctrl: got %b want %b", alu_ctrl, ec);
    end
    step();
    checks++;
    if (result !== er || zero !== ez || branch_taken !== ez || overflow !== 1'b0) begin
      failures++;
      $display("FAIL cfg_result: got r=%h z=%b bt=%b want r=%h z=%b bt=%b",
               result, zero, branch_taken, er, ez, ez);
    end
  endtask

  task automatic test_async_reset();
    drive(2'b10, 6'h20, 32'h0000_00F0, 32'h0000_000F, 1'b0);
    step();
    checks++;
    if (result !== 32'hFF) begin
      failures++;
      $display("FAIL async_pre: got r=%h want 000000ff", result);
    end
    drive(2'b01, 6'h00, 32'd3, 32'd3, 1'b1);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({result, zero, overflow, branch_taken} !== 35'd0) begin
      failures++;
      $display("FAIL async_clear: got r=%h z=%b o=%b bt=%b want all 0",
               result, zero, overflow, branch_taken);
    end
    step();
    #3 rst = 1'b1;
    step();
    checks++;
    if (result !== 32'd0 || zero !== 1'b1 || branch_taken !== 1'b1) begin
      failures++;
      $display("FAIL async_release: got r=%h z=%b bt=%b want r=0 z=1 bt=1", result, zero, branch_taken);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  pool [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h26, 6'h2B, 6'h00, 6'h3F};
    logic [3:0]  ec;
    logic [31:0] er, x, y;
    logic        eo, br;
    logic [1:0]  op;
    logic [5:0]  fn;
    for (int i = 0; i < 300; i++) begin
      op = 2'($urandom);
      fn = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 9)] : 6'($urandom);
      x  = $urandom;
      case ($urandom_range(0, 3))
        0: y = x;
        1: y = {x[31], 31'($urandom)};
        2: y = 32'($urandom_range(0, 3));
        default: y = $urandom;
      endcase
      br = 1'($urandom);
      drive(op, fn, x, y, br);
      model(op, fn, x, y, ec, er, eo);
      #1;
      checks++;
      if (alu_ctrl !== ec) begin
        failures++;
        $display("FAIL rand_ctrl[%0d] op=%b fn=%h: got %b want %b", i, op, fn, alu_ctrl, ec);
      end
      step();
      checks++;
      if (result !== er || zero !== (er == 0) || overflow !== eo || branch_taken !== (br && er == 0)) begin
        failures++;
        $display("FAIL rand_out[%0d] op=%b fn=%h a=%h b=%h: got r=%h z=%b o=%b bt=%b want r=%h z=%b o=%b bt=%b",
                 i, op, fn, x, y, result, zero, overflow, branch_taken,
                 er, (er == 0), eo, (br && er == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype_sweep();
    test_branch();
    test_overflow();
    test_config();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
